qm_mem_arbiter: RTL and testbench

- Shares the single external memory bus between the instruction-cache refill port (burst line fills) and the data-side load/store port.
- Sits between qm_icache (refill side) and the memory/bus interface. The data port serves the future execute/memory stage.
- Sequences each transaction with a small FSM.
- Round-robin grant on contention; one memory beat outstanding at a time.

---
 rtl/qm_mem_pkg.sv | 21 ++
 rtl/qm_rr_arb2.sv | 39 +++
 rtl/qm_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_qm_mem_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qm_mem_pkg.sv
// Shared types and constants for the memory-bus arbiter and its round-robin arbiter.
package qm_mem_pkg;

    localparam int unsigned MEM_ADDR_W    = 32;
    localparam int unsigned MEM_DATA_W    = 32;
    localparam int unsigned WORD_BYTES_LG = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_CMD  = 3'd1,
        ST_I_WAIT = 3'd2,
        ST_D_CMD  = 3'd3,
        ST_D_WAIT = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/qm_rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational, last_grant is registered.
module qm_rr_arb2
    import qm_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic ireq_i,
    input  logic dreq_i,
    output logic igrant_o,
    output logic dgrant_o
);

    grant_e last_q;
    grant_e last_d;
    logic   prefer_d;

    // On contention the side that did not win last time is preferred.
    always_comb begin
        prefer_d = (last_q == GRANT_I);
        igrant_o = en_i & ireq_i & (~dreq_i | ~prefer_d);
        dgrant_o = en_i & dreq_i & (~ireq_i | prefer_d);
        last_d   = last_q;
        if (igrant_o) begin
            last_d = GRANT_I;
        end else if (dgrant_o) begin
            last_d = GRANT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= GRANT_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/qm_mem_arbiter.sv
// Shares one memory bus between icache line refills and single-word data accesses,
// one beat outstanding at a time.
module qm_mem_arbiter
    import qm_mem_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              ireq_ready,
    output logic              iresp_valid,
    output logic [DATA_W-1:0] iresp_data,
    output logic              iresp_last,
    input  logic              dreq_valid,
    input  logic              dreq_we,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              dreq_ready,
    output logic              dresp_valid,
    output logic [DATA_W-1:0] dresp_data,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       BEAT_W    = $clog2(BURST_LEN);
    localparam int unsigned       LINE_LG   = BEAT_W + WORD_BYTES_LG;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << LINE_LG) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'((1 << WORD_BYTES_LG) - 1);
    localparam logic [ADDR_W-1:0] WORD_INC  = ADDR_W'(1 << WORD_BYTES_LG);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                iresp_valid_q, iresp_valid_d;
    logic [DATA_W-1:0]   iresp_data_q, iresp_data_d;
    logic                iresp_last_q, iresp_last_d;
    logic                dresp_valid_q, dresp_valid_d;
    logic [DATA_W-1:0]   dresp_data_q, dresp_data_d;
    logic                arb_en;
    logic                igrant;
    logic                dgrant;

    // Grants are only offered in IDLE and never while reset is held.
    assign arb_en = (state_q == ST_IDLE) & ~reset;

    qm_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .en_i     (arb_en),
        .ireq_i   (ireq_valid),
        .dreq_i   (dreq_valid),
        .igrant_o (igrant),
        .dgrant_o (dgrant)
    );

    assign ireq_ready  = igrant;
    assign dreq_ready  = dgrant;
    assign mem_valid   = mem_valid_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign iresp_valid = iresp_valid_q;
    assign iresp_data  = iresp_data_q;
    assign iresp_last  = iresp_last_q;
    assign dresp_valid = dresp_valid_q;
    assign dresp_data  = dresp_data_q;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        mem_valid_d   = mem_valid_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        iresp_valid_d = 1'b0;
        iresp_data_d  = iresp_data_q;
        iresp_last_d  = 1'b0;
        dresp_valid_d = 1'b0;
        dresp_data_d  = dresp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (igrant) begin
                    state_d     = ST_I_CMD;
                    beat_d      = '0;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ireq_addr & ~LINE_MASK;
                    mem_wdata_d = '0;
                end else if (dgrant) begin
                    state_d     = ST_D_CMD;
                    mem_valid_d = 1'b1;
                    mem_we_d    = dreq_we;
                    mem_addr_d  = dreq_addr & ~WORD_MASK;
                    mem_wdata_d = dreq_wdata;
                end
            end
            ST_I_CMD: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_I_WAIT;
                end
            end
            ST_I_WAIT: begin
                if (mem_rvalid) begin
                    iresp_valid_d = 1'b1;
                    iresp_data_d  = mem_rdata;
                    iresp_last_d  = (beat_q == LAST_BEAT);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Base is line-aligned, so stepping one word never leaves the line.
                        beat_d      = beat_q + BEAT_W'(1);
                        state_d     = ST_I_CMD;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = mem_addr_q + WORD_INC;
                    end
                end
            end
            ST_D_CMD: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    if (mem_we_q) begin
                        dresp_valid_d = 1'b1;
                        dresp_data_d  = '0;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_D_WAIT;
                    end
                end
            end
            ST_D_WAIT: begin
                if (mem_rvalid) begin
                    dresp_valid_d = 1'b1;
                    dresp_data_d  = mem_rdata;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            iresp_valid_q <= 1'b0;
            iresp_data_q  <= '0;
            iresp_last_q  <= 1'b0;
            dresp_valid_q <= 1'b0;
            dresp_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            mem_valid_q   <= mem_valid_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            iresp_valid_q <= iresp_valid_d;
            iresp_data_q  <= iresp_data_d;
            iresp_last_q  <= iresp_last_d;
            dresp_valid_q <= dresp_valid_d;
            dresp_data_q  <= dresp_data_d;
        end
    end

endmodule

// File: tb/tb_qm_mem_arbiter.sv
// Self-checking bench for qm_mem_arbiter: memory responder, response monitors and a
// transaction-level reference model.
module tb_qm_mem_arbiter;

    localparam int unsigned BL = 4;

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
    } cmd_t;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } ir_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        iresp_last;
    logic        dreq_valid;
    logic        dreq_we;
    logic [31:0] dreq_addr;
    logic [31:0] dreq_wdata;
    logic        dreq_ready;
    logic        dresp_valid;
    logic [31:0] dresp_data;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit resp_en = 1'b0;
    int rdy_dly = 0;
    int lat     = 1;

    logic [31:0] mem_a   [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    cmd_t        cmd_q[$];
    ir_t         ir_q[$];
    logic [31:0] dr_q[$];
    bit          grant_q[$];
    int          both_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    qm_mem_arbiter #(.BURST_LEN(BL), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .ireq_ready  (ireq_ready),
        .iresp_valid (iresp_valid),
        .iresp_data  (iresp_data),
        .iresp_last  (iresp_last),
        .dreq_valid  (dreq_valid),
        .dreq_we     (dreq_we),
        .dreq_addr   (dreq_addr),
        .dreq_wdata  (dreq_wdata),
        .dreq_ready  (dreq_ready),
        .dresp_valid (dresp_valid),
        .dresp_data  (dresp_data),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // Memory responder: accepts a command after rdy_dly cycles, returns read data lat cycles later.
    initial begin
        cmd_t c;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk); #2;
            if (resp_en && mem_valid === 1'b1 && reset === 1'b0) begin
                repeat (rdy_dly) begin @(posedge clk); #2; end
                mem_ready = 1'b1;
                c.a  = mem_addr;
                c.we = mem_we;
                c.wd = mem_wdata;
                cmd_q.push_back(c);
                @(posedge clk); #2;
                mem_ready = 1'b0;
                if (c.we) begin
                    mem_a[c.a] = c.wd;
                end else begin
                    repeat (lat - 1) begin @(posedge clk); #2; end
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_a.exists(c.a) ? mem_a[c.a] : pat(c.a);
                    @(posedge clk); #2;
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (iresp_valid === 1'b1) ir_q.push_back({iresp_data, iresp_last === 1'b1});
            if (dresp_valid === 1'b1) dr_q.push_back(dresp_data);
            if (ireq_valid && ireq_ready === 1'b1) grant_q.push_back(1'b0);
            if (dreq_valid && dreq_ready === 1'b1) grant_q.push_back(1'b1);
            if (ireq_ready === 1'b1 && dreq_ready === 1'b1) both_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        cmd_q.delete();
        ir_q.delete();
        dr_q.delete();
        grant_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic issue(input bit is_d, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, output bit ok);
        @(posedge clk); #2;
        if (is_d) begin
            dreq_valid = 1'b1; dreq_addr = a; dreq_we = we; dreq_wdata = wd;
        end else begin
            ireq_valid = 1'b1; ireq_addr = a;
        end
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if ((is_d ? dreq_ready : ireq_ready) === 1'b1) ok = 1'b1;
        end
        @(posedge clk); #2;
        // Scramble request inputs after acceptance; the DUT must not look at them any more.
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        ireq_addr  = $urandom; dreq_addr = $urandom;
        dreq_wdata = $urandom; dreq_we = 1'($urandom_range(0, 1));
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: side=%0d addr=%h got no ready, required ready", is_d, a);
        end
    endtask

    task automatic wait_counts(input int ni, input int nd, input string tag);
        int k = 0;
        while ((ir_q.size() < ni || dr_q.size() < nd) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (ir_q.size() != ni || dr_q.size() != nd) begin
            n_fail++;
            $display("FAIL %s_resp_count: got i=%0d d=%0d, required i=%0d d=%0d",
                     tag, ir_q.size(), dr_q.size(), ni, nd);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({ireq_ready, dreq_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 00", {ireq_ready, dreq_ready});
        end
        n_checks++;
        if ({iresp_valid, iresp_last, iresp_data, dresp_valid, dresp_data} !== '0) begin
            n_fail++; $display("FAIL reset_resp: got iv=%b il=%b id=%h dv=%b dd=%h, required all 0",
                               iresp_valid, iresp_last, iresp_data, dresp_valid, dresp_data);
        end
        n_checks++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_mem: got v=%b we=%b a=%h wd=%h, required all 0",
                               mem_valid, mem_we, mem_addr, mem_wdata);
        end
        repeat (20) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || iresp_valid !== 1'b0 || dresp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL idle_quiet: got %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_refill();
        bit ok;
        resp_en = 1'b1; rdy_dly = 0; lat = 2;
        for (int k = 0; k < 4; k++) mem_a[32'h1040 + 32'(4 * k)] = 32'hA0 + 32'(k);
        clear_logs();
        issue(1'b0, 32'h0000_104C, 1'b0, '0, ok);
        wait_counts(4, 0, "refill");
        n_checks++;
        if (cmd_q.size() != 4) begin
            n_fail++; $display("FAIL refill_cmd_count: got %0d, required 4", cmd_q.size());
        end
        for (int k = 0; k < cmd_q.size() && k < 4; k++) begin
            n_checks++;
            if (cmd_q[k].a !== 32'h1040 + 32'(4 * k) || cmd_q[k].we !== 1'b0) begin
                n_fail++; $display("FAIL refill_addr%0d: got a=%h we=%b, required a=%h we=0",
                                   k, cmd_q[k].a, cmd_q[k].we, 32'h1040 + 32'(4 * k));
            end
        end
        for (int k = 0; k < ir_q.size() && k < 4; k++) begin
            n_checks++;
            if (ir_q[k].d !== 32'hA0 + 32'(k) || ir_q[k].last !== (k == 3)) begin
                n_fail++; $display("FAIL refill_beat%0d: got d=%h last=%b, required d=%h last=%b",
                                   k, ir_q[k].d, ir_q[k].last, 32'hA0 + 32'(k), k == 3);
            end
        end
    endtask

    task automatic test_write_stall();
        bit ok;
        int vcnt = 0;
        int bad  = 0;
        resp_en = 1'b1; rdy_dly = 3; lat = 1;
        clear_logs();
        issue(1'b1, 32'h2003, 1'b1, 32'hDEAD_BEEF, ok);
        repeat (12) begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                vcnt++;
                if (mem_addr !== 32'h2000 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) bad++;
            end
        end
        n_checks++;
        if (vcnt != 4 || bad != 0) begin
            n_fail++; $display("FAIL write_stall_cmd: got %0d valid cycles (%0d unstable), required 4 (0)",
                               vcnt, bad);
        end
        n_checks++;
        if (dr_q.size() != 1) begin
            n_fail++; $display("FAIL write_ack_count: got %0d, required 1", dr_q.size());
        end else if (dr_q[0] !== 32'h0) begin
            n_fail++; $display("FAIL write_ack_data: got %h, required 00000000", dr_q[0]);
        end
    endtask

    task automatic test_contention();
        int  k = 0;
        bit  last_i_side;
        bit  exp_g;
        resp_en = 1'b1; rdy_dly = 0; lat = 1;
        @(posedge clk); #2;
        reset      = 1'b1;
        ireq_valid = 1'b1; ireq_addr  = 32'h9004;
        dreq_valid = 1'b1; dreq_we    = 1'b1;
        dreq_addr  = 32'hA000; dreq_wdata = 32'h1357_9BDF;
        @(negedge clk);
        n_checks++;
        if ({ireq_ready, dreq_ready} !== 2'b00) begin
            n_fail++; $display("FAIL ready_in_reset: got %b, required 00", {ireq_ready, dreq_ready});
        end
        repeat (2) @(posedge clk);
        clear_logs();
        both_cnt = 0;
        #2 reset = 1'b0;
        while (grant_q.size() < 8 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #2;
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        wait_counts(16, 4, "contention");
        n_checks++;
        if (grant_q.size() != 8 || both_cnt != 0) begin
            n_fail++; $display("FAIL contention_grants: got %0d grants, %0d dual-ready, required 8, 0",
                               grant_q.size(), both_cnt);
        end
        last_i_side = 1'b1;
        for (int g = 0; g < grant_q.size() && g < 8; g++) begin
            exp_g       = last_i_side;
            last_i_side = ~exp_g;
            n_checks++;
            if (grant_q[g] !== exp_g) begin
                n_fail++; $display("FAIL grant_order%0d: got %s, required %s",
                                   g, grant_q[g] ? "D" : "I", exp_g ? "D" : "I");
            end
        end
    endtask

    task automatic test_read_then_ireq();
        bit ok;
        int rv_cyc = -1;
        int dr_cyc = -1;
        int gi_cyc = -1;
        int k      = 0;
        resp_en = 1'b1; rdy_dly = 0; lat = 3;
        mem_a[32'h3000] = 32'h1234_5678;
        clear_logs();
        issue(1'b1, 32'h3000, 1'b0, '0, ok);
        ireq_valid = 1'b1; ireq_addr = 32'h7000;
        while (gi_cyc < 0 && k < 200) begin
            @(negedge clk);
            if (mem_rvalid === 1'b1) rv_cyc = cyc;
            if (dresp_valid === 1'b1) dr_cyc = cyc;
            if (ireq_ready === 1'b1) gi_cyc = cyc;
            k++;
        end
        @(posedge clk); #2;
        ireq_valid = 1'b0;
        wait_counts(4, 1, "read_ireq");
        n_checks++;
        if (dr_q.size() != 1 || dr_q[0] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL read_data: got n=%0d d=%h, required n=1 d=12345678",
                               dr_q.size(), dr_q.size() ? dr_q[0] : 32'h0);
        end
        n_checks++;
        if (rv_cyc < 0 || dr_cyc != rv_cyc + 1) begin
            n_fail++; $display("FAIL read_latency: got rvalid@%0d dresp@%0d, required dresp one cycle later",
                               rv_cyc, dr_cyc);
        end
        n_checks++;
        if (dr_cyc < 0 || gi_cyc != dr_cyc) begin
            n_fail++; $display("FAIL ireq_after_idle: got grant@%0d, required %0d", gi_cyc, dr_cyc);
        end
        n_checks++;
        if (cmd_q.size() != 5 || cmd_q[1].a !== 32'h7000 || cmd_q[4].a !== 32'h700C) begin
            n_fail++; $display("FAIL ireq_after_read_cmds: got n=%0d, required 5 with 7000..700C",
                               cmd_q.size());
        end
    endtask

    task automatic wait_mem_valid(input string tag, input logic [31:0] exp_a);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mem_valid !== 1'b1 && k < 50);
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== exp_a || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL %s: got v=%b a=%h we=%b, required v=1 a=%h we=0",
                               tag, mem_valid, mem_addr, mem_we, exp_a);
        end
    endtask

    task automatic test_reset_mid_refill();
        bit ok;
        int mv = 0;
        resp_en = 1'b0;
        clear_logs();
        issue(1'b0, 32'h5008, 1'b0, '0, ok);
        wait_mem_valid("abort_beat0_cmd", 32'h5000);
        @(posedge clk); #2 mem_ready = 1'b1;
        @(posedge clk); #2 mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB0;
        @(posedge clk); #2 mem_rvalid = 1'b0;
        wait_mem_valid("abort_beat1_cmd", 32'h5004);
        @(posedge clk); #2 mem_ready = 1'b1;
        @(posedge clk); #2 mem_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB1;
        @(posedge clk); #2 mem_rvalid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_valid !== 1'b0) mv++;
        end
        n_checks++;
        if (ir_q.size() != 1 || ir_q[0] !== {32'hB0, 1'b0}) begin
            n_fail++; $display("FAIL abort_no_resp: got %0d beats, required exactly beat0 (B0)", ir_q.size());
        end
        n_checks++;
        if (mv != 0) begin
            n_fail++; $display("FAIL abort_idle: got mem_valid %0d cycles after reset, required 0", mv);
        end
        resp_en = 1'b1; rdy_dly = 1; lat = 2;
        mem_a[32'h6000] = 32'h0BAD_F00D;
        clear_logs();
        issue(1'b1, 32'h6001, 1'b0, '0, ok);
        wait_counts(0, 1, "post_abort");
        n_checks++;
        if (dr_q.size() != 1 || dr_q[0] !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL post_abort_read: got n=%0d d=%h, required n=1 d=0badf00d",
                               dr_q.size(), dr_q.size() ? dr_q[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        bit          ok;
        bit          side;
        logic        we;
        logic [31:0] a, wd, base, exp_d;
        for (int t = 0; t < 24; t++) begin
            side    = 1'($urandom_range(0, 1));
            a       = 32'h8000 | 32'($urandom_range(0, 255));
            we      = 1'($urandom_range(0, 1));
            wd      = $urandom;
            rdy_dly = $urandom_range(0, 3);
            lat     = $urandom_range(1, 3);
            clear_logs();
            issue(side, a, we, wd, ok);
            if (!side) begin
                base = a - (a % (BL * 4));
                wait_counts(BL, 0, "rand_refill");
                n_checks++;
                if (cmd_q.size() != BL) begin
                    n_fail++; $display("FAIL rand_refill_cmds t%0d: got %0d, required %0d", t, cmd_q.size(), BL);
                end
                for (int k = 0; k < cmd_q.size() && k < BL; k++) begin
                    n_checks++;
                    if (cmd_q[k].a !== base + 32'(4 * k) || cmd_q[k].we !== 1'b0) begin
                        n_fail++; $display("FAIL rand_refill_addr t%0d.%0d: got %h, required %h",
                                           t, k, cmd_q[k].a, base + 32'(4 * k));
                    end
                end
                for (int k = 0; k < ir_q.size() && k < BL; k++) begin
                    exp_d = ref_rd(base + 32'(4 * k));
                    n_checks++;
                    if (ir_q[k].d !== exp_d || ir_q[k].last !== (k == BL - 1)) begin
                        n_fail++; $display("FAIL rand_refill_data t%0d.%0d: got %h/%b, required %h/%b",
                                           t, k, ir_q[k].d, ir_q[k].last, exp_d, k == BL - 1);
                    end
                end
            end else begin
                base  = a - (a % 4);
                exp_d = we ? 32'h0 : ref_rd(base);
                if (we) ref_mem[base] = wd;
                wait_counts(0, 1, "rand_data");
                n_checks++;
                if (cmd_q.size() != 1 || cmd_q[0].a !== base || cmd_q[0].we !== we
                    || (we && cmd_q[0].wd !== wd)) begin
                    n_fail++; $display("FAIL rand_data_cmd t%0d: got n=%0d, required a=%h we=%b wd=%h",
                                       t, cmd_q.size(), base, we, wd);
                end
                n_checks++;
                if (dr_q.size() != 1 || dr_q[0] !== exp_d) begin
                    n_fail++; $display("FAIL rand_data_resp t%0d: got n=%0d d=%h, required %h",
                                       t, dr_q.size(), dr_q.size() ? dr_q[0] : 32'h0, exp_d);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        ireq_valid = 1'b0;
        ireq_addr  = '0;
        dreq_valid = 1'b0;
        dreq_we    = 1'b0;
        dreq_addr  = '0;
        dreq_wdata = '0;
        test_reset();
        test_refill();
        test_write_stall();
        test_contention();
        test_read_then_ireq();
        test_reset_mid_refill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
